// File: rtl/ldst_ahb_arbiter.sv
// Two-master AHB-Lite arbiter sharing the data-memory port between ldst0 (older slot) and
// ldst1 (younger slot). Address phases are buffered per slot and issued one at a time in capture order.
module ldst_ahb_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        m0_HTRANS,
  input  logic [ADDR_W-1:0] m0_HADDR,
  input  logic              m0_HWRITE,
  input  logic [2:0]        m0_HSIZE,
  input  logic [DATA_W-1:0] m0_HWDATA,
  output logic              m0_HREADY,
  output logic              m0_HRESP,
  output logic [DATA_W-1:0] m0_HRDATA,
  input  logic [1:0]        m1_HTRANS,
  input  logic [ADDR_W-1:0] m1_HADDR,
  input  logic              m1_HWRITE,
  input  logic [2:0]        m1_HSIZE,
  input  logic [DATA_W-1:0] m1_HWDATA,
  output logic              m1_HREADY,
  output logic              m1_HRESP,
  output logic [DATA_W-1:0] m1_HRDATA,
  output logic [1:0]        s_HTRANS,
  output logic [ADDR_W-1:0] s_HADDR,
  output logic              s_HWRITE,
  output logic [2:0]        s_HSIZE,
  output logic [DATA_W-1:0] s_HWDATA,
  input  logic              s_HREADY,
  input  logic              s_HRESP,
  input  logic [DATA_W-1:0] s_HRDATA,
  output logic [3:0]        dbg_slot_state
);

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_PEND = 2'd1,
    SLOT_APH  = 2'd2,
    SLOT_DPH  = 2'd3
  } slot_st_e;

  slot_st_e          st_q    [2];
  slot_st_e          st_d    [2];
  logic [ADDR_W-1:0] baddr_q [2];
  logic [ADDR_W-1:0] baddr_d [2];
  logic              bwrite_q[2];
  logic              bwrite_d[2];
  logic [2:0]        bsize_q [2];
  logic [2:0]        bsize_d [2];
  logic              age_q, age_d;
  logic              trans_q, trans_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;

  logic              in_req  [2];
  logic [ADDR_W-1:0] in_addr [2];
  logic              in_write[2];
  logic [2:0]        in_size [2];
  logic              rdy     [2];
  logic              cap     [2];
  logic              req     [2];
  logic              issue   [2];
  logic              older1;
  logic              sel1;
  logic              unused_trans;

  assign in_req[0]   = m0_HTRANS[1];
  assign in_req[1]   = m1_HTRANS[1];
  assign in_addr[0]  = m0_HADDR;
  assign in_addr[1]  = m1_HADDR;
  assign in_write[0] = m0_HWRITE;
  assign in_write[1] = m1_HWRITE;
  assign in_size[0]  = m0_HSIZE;
  assign in_size[1]  = m1_HSIZE;
  assign unused_trans = m0_HTRANS[0] ^ m1_HTRANS[0];

  // Handshakes: a slot transfer is accepted at a rising edge where mN_HTRANS[1] and mN_HREADY
  // are both high; the slave accepts the registered address phase at an edge where s_HREADY is high.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      rdy[n] = 1'b0;
      if (st_q[n] == SLOT_IDLE)     rdy[n] = 1'b1;
      else if (st_q[n] == SLOT_DPH) rdy[n] = s_HREADY;
      cap[n] = in_req[n] && rdy[n];
      req[n] = (st_q[n] == SLOT_PEND) || cap[n];
    end
  end

  // A buffered request always beats a fresh capture; two buffered ones are ordered by age_q.
  always_comb begin
    older1   = (st_q[1] == SLOT_PEND) && ((st_q[0] != SLOT_PEND) || age_q);
    sel1     = req[1] && (!req[0] || older1);
    issue[0] = s_HREADY && req[0] && !sel1;
    issue[1] = s_HREADY && sel1;
    for (int n = 0; n < 2; n++) begin
      st_d[n]     = st_q[n];
      baddr_d[n]  = baddr_q[n];
      bwrite_d[n] = bwrite_q[n];
      bsize_d[n]  = bsize_q[n];
      if (cap[n]) begin
        baddr_d[n]  = in_addr[n];
        bwrite_d[n] = in_write[n];
        bsize_d[n]  = in_size[n];
        st_d[n]     = issue[n] ? SLOT_APH : SLOT_PEND;
      end else begin
        case (st_q[n])
          SLOT_PEND: if (issue[n]) st_d[n] = SLOT_APH;
          SLOT_APH:  if (s_HREADY) st_d[n] = SLOT_DPH;
          SLOT_DPH:  if (s_HREADY) st_d[n] = SLOT_IDLE;
          default:   st_d[n] = st_q[n];
        endcase
      end
    end

    age_d = age_q;
    if ((st_d[0] == SLOT_PEND) && (st_d[1] == SLOT_PEND) &&
        !((st_q[0] == SLOT_PEND) && (st_q[1] == SLOT_PEND)))
      age_d = (st_q[1] == SLOT_PEND);

    trans_d = trans_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    if (s_HREADY) begin
      trans_d = issue[0] || issue[1];
      if (trans_d) begin
        addr_d  = cap[sel1] ? in_addr[sel1]  : baddr_q[sel1];
        write_d = cap[sel1] ? in_write[sel1] : bwrite_q[sel1];
        size_d  = cap[sel1] ? in_size[sel1]  : bsize_q[sel1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int n = 0; n < 2; n++) begin
        st_q[n]     <= SLOT_IDLE;
        baddr_q[n]  <= '0;
        bwrite_q[n] <= 1'b0;
        bsize_q[n]  <= 3'd0;
      end
      age_q   <= 1'b0;
      trans_q <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        st_q[n]     <= st_d[n];
        baddr_q[n]  <= baddr_d[n];
        bwrite_q[n] <= bwrite_d[n];
        bsize_q[n]  <= bsize_d[n];
      end
      age_q   <= age_d;
      trans_q <= trans_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  assign m0_HREADY = rdy[0];
  assign m1_HREADY = rdy[1];
  assign m0_HRESP  = (st_q[0] == SLOT_DPH) && s_HRESP;
  assign m1_HRESP  = (st_q[1] == SLOT_DPH) && s_HRESP;
  assign m0_HRDATA = s_HRDATA;
  assign m1_HRDATA = s_HRDATA;
  assign s_HTRANS  = trans_q ? 2'h2 : 2'h0;
  assign s_HADDR   = addr_q;
  assign s_HWRITE  = write_q;
  assign s_HSIZE   = size_q;
  assign s_HWDATA  = (st_q[0] == SLOT_DPH) ? m0_HWDATA :
                     (st_q[1] == SLOT_DPH) ? m1_HWDATA : '0;
  assign dbg_slot_state = {st_q[1], st_q[0]};

endmodule

// File: tb/tb_ldst_ahb_arbiter.sv
// Self-checking bench for ldst_ahb_arbiter: directed scenarios plus a randomized run
// checked against a FIFO-ordered transaction model of the arbiter.
module tb_ldst_ahb_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              CLK, RST;
  logic [1:0]        m0_HTRANS, m1_HTRANS;
  logic [ADDR_W-1:0] m0_HADDR, m1_HADDR;
  logic              m0_HWRITE, m1_HWRITE;
  logic [2:0]        m0_HSIZE, m1_HSIZE;
  logic [DATA_W-1:0] m0_HWDATA, m1_HWDATA;
  logic              m0_HREADY, m1_HREADY, m0_HRESP, m1_HRESP;
  logic [DATA_W-1:0] m0_HRDATA, m1_HRDATA;
  logic [1:0]        s_HTRANS;
  logic [ADDR_W-1:0] s_HADDR;
  logic              s_HWRITE;
  logic [2:0]        s_HSIZE;
  logic [DATA_W-1:0] s_HWDATA;
  logic              s_HREADY, s_HRESP;
  logic [DATA_W-1:0] s_HRDATA;
  logic [3:0]        dbg_slot_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pending slots in age order, owners of the slave address and data phases.
  int                q_slot[$];
  int                m_aph, m_dph;
  logic [ADDR_W-1:0] pa[2];
  logic              pw[2];
  logic [2:0]        ps[2];
  logic              e_trans;
  logic [ADDR_W-1:0] e_addr;
  logic              e_write;
  logic [2:0]        e_size;

  ldst_ahb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RST(RST),
    .m0_HTRANS(m0_HTRANS), .m0_HADDR(m0_HADDR), .m0_HWRITE(m0_HWRITE), .m0_HSIZE(m0_HSIZE),
    .m0_HWDATA(m0_HWDATA), .m0_HREADY(m0_HREADY), .m0_HRESP(m0_HRESP), .m0_HRDATA(m0_HRDATA),
    .m1_HTRANS(m1_HTRANS), .m1_HADDR(m1_HADDR), .m1_HWRITE(m1_HWRITE), .m1_HSIZE(m1_HSIZE),
    .m1_HWDATA(m1_HWDATA), .m1_HREADY(m1_HREADY), .m1_HRESP(m1_HRESP), .m1_HRDATA(m1_HRDATA),
    .s_HTRANS(s_HTRANS), .s_HADDR(s_HADDR), .s_HWRITE(s_HWRITE), .s_HSIZE(s_HSIZE),
    .s_HWDATA(s_HWDATA), .s_HREADY(s_HREADY), .s_HRESP(s_HRESP), .s_HRDATA(s_HRDATA),
    .dbg_slot_state(dbg_slot_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    m0_HTRANS = 2'h0; m0_HADDR = '0; m0_HWRITE = 1'b0; m0_HSIZE = 3'd0; m0_HWDATA = '0;
    m1_HTRANS = 2'h0; m1_HADDR = '0; m1_HWRITE = 1'b0; m1_HSIZE = 3'd0; m1_HWDATA = '0;
    s_HREADY = 1'b1; s_HRESP = 1'b0; s_HRDATA = '0;
  endtask

  task automatic set_m(input int n, input logic [1:0] tr, input logic [ADDR_W-1:0] a,
                       input logic w, input logic [2:0] sz);
    if (n == 0) begin
      m0_HTRANS = tr; m0_HADDR = a; m0_HWRITE = w; m0_HSIZE = sz;
    end else begin
      m1_HTRANS = tr; m1_HADDR = a; m1_HWRITE = w; m1_HSIZE = sz;
    end
  endtask

  function automatic logic exp_ready(input int n);
    if (m_dph == n) return s_HREADY;
    if (m_aph == n) return 1'b0;
    foreach (q_slot[i]) if (q_slot[i] == n) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q_slot.delete();
    m_aph = -1; m_dph = -1;
    e_trans = 1'b0; e_addr = '0; e_write = 1'b0; e_size = 3'd0;
  endtask

  task automatic model_step();
    logic c0, c1;
    c0 = m0_HTRANS[1] && exp_ready(0);
    c1 = m1_HTRANS[1] && exp_ready(1);
    if (c0) begin q_slot.push_back(0); pa[0] = m0_HADDR; pw[0] = m0_HWRITE; ps[0] = m0_HSIZE; end
    if (c1) begin q_slot.push_back(1); pa[1] = m1_HADDR; pw[1] = m1_HWRITE; ps[1] = m1_HSIZE; end
    if (s_HREADY) begin
      m_dph = m_aph;
      if (q_slot.size() > 0) begin
        m_aph = q_slot.pop_front();
        e_trans = 1'b1; e_addr = pa[m_aph]; e_write = pw[m_aph]; e_size = ps[m_aph];
      end else begin
        m_aph = -1;
        e_trans = 1'b0;
      end
    end
  endtask

  task automatic advance();
    model_step();
    tick();
  endtask

  task automatic do_reset();
    drive_idle();
    RST = 1'b0;
    model_reset();
    tick();
    tick();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    s_HRESP = 1'b1;
    RST = 1'b0;
    model_reset();
    #2;
    n_checks++; if (s_HTRANS !== 2'h0) begin n_fail++; $display("FAIL rst_htrans: got %h want 0", s_HTRANS); end
    n_checks++; if (s_HADDR !== '0) begin n_fail++; $display("FAIL rst_haddr: got %h want 0", s_HADDR); end
    n_checks++; if ({s_HWRITE, s_HSIZE} !== 4'h0) begin n_fail++; $display("FAIL rst_write_size: got %h want 0", {s_HWRITE, s_HSIZE}); end
    n_checks++; if ({m0_HREADY, m1_HREADY} !== 2'b11) begin n_fail++; $display("FAIL rst_hready: got %b want 11", {m0_HREADY, m1_HREADY}); end
    n_checks++; if ({m0_HRESP, m1_HRESP} !== 2'b00) begin n_fail++; $display("FAIL rst_hresp: got %b want 00", {m0_HRESP, m1_HRESP}); end
    tick();
    s_HRESP = 1'b0;
    RST = 1'b1;
    set_m(0, 2'h2, 32'h3000, 1'b0, 3'd2);
    settle();
    advance();
    set_m(0, 2'h0, 32'h0, 1'b0, 3'd0);
    settle();
    advance();
    s_HREADY = 1'b0;
    s_HRESP = 1'b1;
    settle();
    n_checks++; if ({m0_HREADY, m0_HRESP} !== 2'b01) begin n_fail++; $display("FAIL mid_dph_pre: got %b want 01", {m0_HREADY, m0_HRESP}); end
    RST = 1'b0;
    model_reset();
    tick();
    n_checks++; if (s_HTRANS !== 2'h0) begin n_fail++; $display("FAIL mid_rst_htrans: got %h want 0", s_HTRANS); end
    n_checks++; if (m0_HREADY !== 1'b1) begin n_fail++; $display("FAIL mid_rst_hready: got %b want 1", m0_HREADY); end
    n_checks++; if (m0_HRESP !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hresp: got %b want 0", m0_HRESP); end
    RST = 1'b1;
    s_HREADY = 1'b1;
    s_HRESP = 1'b0;
    settle();
    advance();
    n_checks++; if (s_HTRANS !== 2'h0) begin n_fail++; $display("FAIL mid_rst_no_replay: got %h want 0", s_HTRANS); end
  endtask

  task automatic test_single_read();
    do_reset();
    set_m(0, 2'h2, 32'h1000, 1'b0, 3'd2);
    settle();
    n_checks++; if (m0_HREADY !== 1'b1) begin n_fail++; $display("FAIL rd_req_ready: got %b want 1", m0_HREADY); end
    advance();
    set_m(0, 2'h0, 32'h0, 1'b0, 3'd0);
    settle();
    n_checks++; if (s_HTRANS !== 2'h2) begin n_fail++; $display("FAIL rd_aph_htrans: got %h want 2", s_HTRANS); end
    n_checks++; if (s_HADDR !== 32'h1000) begin n_fail++; $display("FAIL rd_aph_haddr: got %h want 1000", s_HADDR); end
    n_checks++; if ({s_HWRITE, s_HSIZE} !== 4'h2) begin n_fail++; $display("FAIL rd_aph_attr: got %h want 2", {s_HWRITE, s_HSIZE}); end
    n_checks++; if (m0_HREADY !== 1'b0) begin n_fail++; $display("FAIL rd_aph_ready: got %b want 0", m0_HREADY); end
    advance();
    s_HRDATA = 32'hDEADBEEF;
    settle();
    n_checks++; if (m0_HREADY !== 1'b1) begin n_fail++; $display("FAIL rd_dph_ready: got %b want 1", m0_HREADY); end
    n_checks++; if (m0_HRDATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_dph_rdata: got %h want deadbeef", m0_HRDATA); end
    n_checks++; if (s_HTRANS !== 2'h0) begin n_fail++; $display("FAIL rd_dph_htrans: got %h want 0", s_HTRANS); end
    advance();
  endtask

  task automatic test_simultaneous();
    do_reset();
    m0_HWDATA = 32'h11;
    m1_HWDATA = 32'hBB;
    set_m(0, 2'h2, 32'h2000, 1'b1, 3'd2);
    set_m(1, 2'h2, 32'h2004, 1'b0, 3'd2);
    settle();
    advance();
    set_m(0, 2'h0, 32'h0, 1'b0, 3'd0);
    set_m(1, 2'h0, 32'h0, 1'b0, 3'd0);
    settle();
    n_checks++; if ({s_HTRANS, s_HWRITE} !== 3'b101 || s_HADDR !== 32'h2000) begin n_fail++; $display("FAIL sim_aph0: got %h/%b want 2000/101", s_HADDR, {s_HTRANS, s_HWRITE}); end
    n_checks++; if (m1_HREADY !== 1'b0) begin n_fail++; $display("FAIL sim_m1_ready_t1: got %b want 0", m1_HREADY); end
    advance();
    settle();
    n_checks++; if ({s_HTRANS, s_HWRITE} !== 3'b100 || s_HADDR !== 32'h2004) begin n_fail++; $display("FAIL sim_aph1: got %h/%b want 2004/100", s_HADDR, {s_HTRANS, s_HWRITE}); end
    n_checks++; if (s_HWDATA !== 32'h11) begin n_fail++; $display("FAIL sim_hwdata: got %h want 11", s_HWDATA); end
    n_checks++; if ({m0_HREADY, m1_HREADY} !== 2'b10) begin n_fail++; $display("FAIL sim_ready_t2: got %b want 10", {m0_HREADY, m1_HREADY}); end
    advance();
    s_HRDATA = 32'h5555AAAA;
    settle();
    n_checks++; if (m1_HREADY !== 1'b1 || m1_HRDATA !== 32'h5555AAAA) begin n_fail++; $display("FAIL sim_m1_dph: got %b/%h want 1/5555aaaa", m1_HREADY, m1_HRDATA); end
    n_checks++; if (s_HWDATA !== 32'hBB) begin n_fail++; $display("FAIL sim_hwdata_m1: got %h want bb", s_HWDATA); end
    advance();
  endtask

  task automatic test_age();
    do_reset();
    s_HREADY = 1'b0;
    set_m(1, 2'h2, 32'h4104, 1'b0, 3'd2);
    settle();
    advance();
    set_m(1, 2'h0, 32'h0, 1'b0, 3'd0);
    set_m(0, 2'h2, 32'h4000, 1'b1, 3'd2);
    settle();
    advance();
    set_m(0, 2'h0, 32'h0, 1'b0, 3'd0);
    settle();
    n_checks++; if ({m0_HREADY, m1_HREADY, s_HTRANS} !== 4'b0000) begin n_fail++; $display("FAIL age_stall: got %b want 0000", {m0_HREADY, m1_HREADY, s_HTRANS}); end
    advance();
    s_HREADY = 1'b1;
    settle();
    advance();
    settle();
    n_checks++; if (s_HTRANS !== 2'h2 || s_HADDR !== 32'h4104) begin n_fail++; $display("FAIL age_first: got %h/%h want 2/4104", s_HTRANS, s_HADDR); end
    advance();
    settle();
    n_checks++; if (s_HTRANS !== 2'h2 || s_HADDR !== 32'h4000 || s_HWRITE !== 1'b1) begin n_fail++; $display("FAIL age_second: got %h/%h/%b want 2/4000/1", s_HTRANS, s_HADDR, s_HWRITE); end
    advance();
  endtask

  task automatic test_wait_states();
    do_reset();
    set_m(1, 2'h2, 32'h5000, 1'b0, 3'd2);
    settle();
    advance();
    set_m(1, 2'h0, 32'h0, 1'b0, 3'd0);
    set_m(0, 2'h2, 32'h6000, 1'b1, 3'd1);
    settle();
    advance();
    set_m(0, 2'h0, 32'h0, 1'b0, 3'd0);
    for (int i = 0; i < 2; i++) begin
      s_HREADY = 1'b0;
      settle();
      n_checks++; if (s_HADDR !== 32'h6000 || s_HTRANS !== 2'h2) begin n_fail++; $display("FAIL ws_hold_%0d: got %h/%h want 6000/2", i, s_HADDR, s_HTRANS); end
      n_checks++; if (m1_HREADY !== 1'b0) begin n_fail++; $display("FAIL ws_m1_ready_%0d: got %b want 0", i, m1_HREADY); end
      advance();
    end
    s_HREADY = 1'b1;
    settle();
    n_checks++; if (m1_HREADY !== 1'b1 || s_HADDR !== 32'h6000) begin n_fail++; $display("FAIL ws_release: got %b/%h want 1/6000", m1_HREADY, s_HADDR); end
    advance();
    settle();
    n_checks++; if ({s_HTRANS, m0_HREADY, m1_HREADY} !== 4'b0011) begin n_fail++; $display("FAIL ws_m0_dph: got %b want 0011", {s_HTRANS, m0_HREADY, m1_HREADY}); end
    advance();
  endtask

  task automatic test_error();
    do_reset();
    set_m(0, 2'h2, 32'h7000, 1'b0, 3'd2);
    settle();
    advance();
    set_m(0, 2'h0, 32'h0, 1'b0, 3'd0);
    set_m(1, 2'h2, 32'h7100, 1'b0, 3'd2);
    settle();
    advance();
    set_m(1, 2'h0, 32'h0, 1'b0, 3'd0);
    s_HRESP = 1'b1;
    s_HREADY = 1'b0;
    settle();
    n_checks++; if ({m0_HRESP, m0_HREADY} !== 2'b10) begin n_fail++; $display("FAIL err_cycle1: got %b want 10", {m0_HRESP, m0_HREADY}); end
    n_checks++; if ({m1_HRESP, m1_HREADY} !== 2'b00) begin n_fail++; $display("FAIL err_m1_cycle1: got %b want 00", {m1_HRESP, m1_HREADY}); end
    advance();
    s_HREADY = 1'b1;
    settle();
    n_checks++; if ({m0_HRESP, m0_HREADY, m1_HRESP} !== 3'b110) begin n_fail++; $display("FAIL err_cycle2: got %b want 110", {m0_HRESP, m0_HREADY, m1_HRESP}); end
    advance();
    s_HRESP = 1'b0;
    settle();
    n_checks++; if ({m1_HREADY, m1_HRESP, m0_HRESP} !== 3'b100) begin n_fail++; $display("FAIL err_after: got %b want 100", {m1_HREADY, m1_HRESP, m0_HRESP}); end
    advance();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] cur_wd[2];
    logic              err_st;
    logic              c0, c1;
    logic [DATA_W-1:0] e_wd;
    do_reset();
    err_st = 1'b0;
    cur_wd[0] = $urandom;
    cur_wd[1] = $urandom;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int n = 0; n < 2; n++)
        set_m(n, 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)));
      m0_HWDATA = cur_wd[0];
      m1_HWDATA = cur_wd[1];
      if (err_st) begin
        s_HRESP = 1'b1; s_HREADY = 1'b1; err_st = 1'b0;
      end else if (m_dph >= 0 && $urandom_range(0, 15) == 0) begin
        s_HRESP = 1'b1; s_HREADY = 1'b0; err_st = 1'b1;
      end else begin
        s_HRESP = 1'b0; s_HREADY = ($urandom_range(0, 3) != 0);
      end
      s_HRDATA = $urandom;
      settle();
      for (int n = 0; n < 2; n++) begin
        logic got_rdy, got_resp, e_rdy, e_resp;
        logic [DATA_W-1:0] got_rd;
        got_rdy  = (n == 0) ? m0_HREADY : m1_HREADY;
        got_resp = (n == 0) ? m0_HRESP : m1_HRESP;
        got_rd   = (n == 0) ? m0_HRDATA : m1_HRDATA;
        e_rdy    = exp_ready(n);
        e_resp   = (m_dph == n) && s_HRESP;
        n_checks++; if (got_rdy !== e_rdy) begin n_fail++; $display("FAIL rnd_hready%0d cyc %0d: got %b want %b", n, cyc, got_rdy, e_rdy); end
        n_checks++; if (got_resp !== e_resp) begin n_fail++; $display("FAIL rnd_hresp%0d cyc %0d: got %b want %b", n, cyc, got_resp, e_resp); end
        n_checks++; if (got_rd !== s_HRDATA) begin n_fail++; $display("FAIL rnd_hrdata%0d cyc %0d: got %h want %h", n, cyc, got_rd, s_HRDATA); end
      end
      n_checks++; if (s_HTRANS !== {e_trans, 1'b0}) begin n_fail++; $display("FAIL rnd_htrans cyc %0d: got %h want %h", cyc, s_HTRANS, {e_trans, 1'b0}); end
      if (e_trans) begin
        n_checks++;
        if (s_HADDR !== e_addr || s_HWRITE !== e_write || s_HSIZE !== e_size) begin
          n_fail++;
          $display("FAIL rnd_aph cyc %0d: got %h/%b/%0d want %h/%b/%0d", cyc, s_HADDR, s_HWRITE, s_HSIZE, e_addr, e_write, e_size);
        end
      end
      e_wd = (m_dph == 0) ? cur_wd[0] : (m_dph == 1) ? cur_wd[1] : '0;
      n_checks++; if (s_HWDATA !== e_wd) begin n_fail++; $display("FAIL rnd_hwdata cyc %0d: got %h want %h", cyc, s_HWDATA, e_wd); end
      c0 = m0_HTRANS[1] && exp_ready(0);
      c1 = m1_HTRANS[1] && exp_ready(1);
      advance();
      if (c0) cur_wd[0] = $urandom;
      if (c1) cur_wd[1] = $urandom;
    end
  endtask

  initial begin
    drive_idle();
    RST = 1'b0;
    model_reset();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_age();
    test_wait_states();
    test_error();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
